regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the single write port of the 32×32 register unit. Two producers, ALU write-back and memory-load write-back, each deliver results through a valid/ready handshake into a one-entry holding slot. The block grants at most one slot per cycle onto registered `ru_wr`/`rd`/`data_wr` outputs and preserves per-register write order. It drops architecturally dead writes and exports a busy mask of pending destinations for hazard/stall logic.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register address width.
- `PROTECT_X2`, default 1: when 1, writes to x2 (read-only stack pointer) are dropped.
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `alu_valid`, input, 1: ALU result offered.
- `alu_ready`, output, 1: ALU slot can accept.
- `alu_rd`, input, ADDR_W: ALU destination register.
- `alu_data`, input, DATA_W: ALU result.
- `mem_valid`, input, 1: load result offered.
- `mem_ready`, output, 1: MEM slot can accept.
- `mem_rd`, input, ADDR_W: load destination register.
- `mem_data`, input, DATA_W: load data.
- `ru_wr`, output, 1: register-unit write enable (registered).
- `rd`, output, ADDR_W: register-unit write address (registered).
- `data_wr`, output, DATA_W: register-unit write data (registered).
- `busy_mask`, output, 32: bit r set while a write to xr is held in a slot or on the outputs.
- `conflict_cnt`, output, 16: saturating count of cycles with both slots full.

## Operation
- Slot state per requester: full flag, rd, data, age bit. Age bit is set when the slot was captured strictly before the other currently full slot.
- Handshake: transfer on `valid && ready` at a rising edge. `ready = !full || granted_this_cycle`, so a single requester sustains one result per cycle. `valid` may drop without a transfer; no data is held for the requester.
- Drop rule: a transfer with rd==0, or with rd==2 when PROTECT_X2=1, completes the handshake but leaves the slot unchanged. It never reaches the outputs and never sets `busy_mask`.
- Arbitration (combinational, each cycle):
  - One slot full: grant it.
  - Both full, same rd: grant the older slot. If both were captured on the same edge, grant MEM first.
  - Both full, different rd: round-robin. Grant the requester not granted last; `last_grant` resets to MEM, so ALU wins the first contest.
- On a grant edge: the granted slot empties, or is refilled if its requester transfers that edge. Outputs load {1, slot.rd, slot.data}. With no grant, `ru_wr` is 0 and `rd`/`data_wr` hold their previous values.
- `busy_mask` = OR of one-hot(rd) over full slots, plus one-hot(`rd`) when `ru_wr`=1. Combinational from registered state only.
- `conflict_cnt` increments each cycle both slots are full, saturating at 0xFFFF.

## Timing
- Reset (async assert, synchronous release): slots empty, `ru_wr`=0, `rd`=0, `data_wr`=0, `last_grant`=MEM, `conflict_cnt`=0. Therefore `busy_mask`=0 and both readies are 1.
- Latency with an idle slot: transfer at edge E0, outputs valid after E1, register file updated at E2.
- Back-to-back writes to the same rd from the same requester reach the outputs in transfer order on consecutive edges.
- Loser of a contest waits exactly one cycle when the winner's requester goes idle. Under sustained traffic from both requesters, each gets one grant every two cycles.
- Reset asserted mid-operation: all pending writes are discarded. `ru_wr` falls asynchronously, so no partial write reaches the register unit.

## Structure
- Package `regfile_pkg`: `ADDR_W`, `DATA_W`, `REG_ZERO`=5'd0, `REG_SP`=5'd2, enum `wb_req_e` {`WB_ALU`, `WB_MEM`}, struct `wb_req_t` {rd, data}. Shared with the register unit and hazard logic.
- Sub-module `wb_slot`: one holding slot with handshake, drop filter and full flag, instantiated twice. Arbitration, age tracking, output registers and the counter stay in the top.

## Test plan
- Reset, then ALU writes x5=0xDEADBEEF → `alu_ready`=1 throughout. `ru_wr`=1, `rd`=5, `data_wr`=0xDEADBEEF one cycle after the transfer. `busy_mask`[5] is high for 2 cycles.
- ALU rd=0 data=0x1 and MEM rd=2 data=0x2 on the same edge (PROTECT_X2=1) → both handshakes complete, `ru_wr` stays 0, `busy_mask` stays 0.
- ALU x7=0xA and MEM x7=0xB on the same edge → MEM written first, then ALU. x7 ends at 0xA. `conflict_cnt`=1.
- Both requesters stream to distinct regs (ALU x10.., MEM x20..) for 10 cycles → alternating grants starting with ALU. Each ready is high every other cycle. `conflict_cnt` increments each both-full cycle.
- Fill both slots, assert `rstn`=0 mid-cycle → `ru_wr`=0 immediately. After release, `busy_mask`=0, `conflict_cnt`=0, and no write to either pending rd occurs.
- Hold both slots full for 70000 cycles → `conflict_cnt` saturates at 0xFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register unit, its write-back arbiter and hazard logic.
// Provides register-file geometry, special register indices, the write-back
// requester enum and the request payload struct.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // x0 is hard-wired zero; x2 is the stack pointer, optionally read-only.
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd2;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_req_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_slot.sv
// One-entry write-back holding slot with valid/ready handshake and dead-write filter.
// Ports: clk/rstn; requester side valid/ready/req_rd/req_data; arbiter side
//   grant in, full/hold_rd/hold_data/capture out (capture = new entry loaded this edge).
module wb_slot #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit PROTECT_X2 = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [DATA_W-1:0] req_data,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] hold_rd,
  output logic [DATA_W-1:0] hold_data,
  output logic              capture
);
  import regfile_pkg::REG_ZERO;
  import regfile_pkg::REG_SP;

  logic dead;

  // A slot being drained this cycle can take a new entry on the same edge.
  assign ready = !full || grant;

  // Dead writes complete the handshake but never occupy the slot.
  assign dead    = (req_rd == ADDR_W'(REG_ZERO)) ||
                   (PROTECT_X2 && (req_rd == ADDR_W'(REG_SP)));
  assign capture = valid && ready && !dead;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full      <= 1'b0;
      hold_rd   <= '0;
      hold_data <= '0;
    end else if (capture) begin
      full      <= 1'b1;
      hold_rd   <= req_rd;
      hold_data <= req_data;
    end else if (grant) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two holding slots (ALU, MEM) share the register unit write port.
// Ports: clk/rstn; alu_*/mem_* valid/ready producer handshakes; registered ru_wr/rd/data_wr;
//   busy_mask of pending destinations; saturating conflict_cnt of both-full cycles.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit PROTECT_X2 = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              ru_wr,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data_wr,
  output logic [31:0]       busy_mask,
  output logic [15:0]       conflict_cnt
);
  import regfile_pkg::wb_req_e;
  import regfile_pkg::WB_ALU;
  import regfile_pkg::WB_MEM;

  logic              alu_full, mem_full;
  logic [ADDR_W-1:0] alu_hold_rd, mem_hold_rd;
  logic [DATA_W-1:0] alu_hold_data, mem_hold_data;
  logic              alu_cap, mem_cap;
  logic              grant_alu, grant_mem;
  logic              alu_full_nxt, mem_full_nxt;
  logic              age_alu, age_mem;
  logic              both_full;
  wb_req_e           last_grant;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROTECT_X2(PROTECT_X2)) u_alu_slot (
    .clk(clk), .rstn(rstn),
    .valid(alu_valid), .ready(alu_ready), .req_rd(alu_rd), .req_data(alu_data),
    .grant(grant_alu), .full(alu_full), .hold_rd(alu_hold_rd), .hold_data(alu_hold_data),
    .capture(alu_cap)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROTECT_X2(PROTECT_X2)) u_mem_slot (
    .clk(clk), .rstn(rstn),
    .valid(mem_valid), .ready(mem_ready), .req_rd(mem_rd), .req_data(mem_data),
    .grant(grant_mem), .full(mem_full), .hold_rd(mem_hold_rd), .hold_data(mem_hold_data),
    .capture(mem_cap)
  );

  assign both_full = alu_full && mem_full;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (both_full) begin
      if (alu_hold_rd == mem_hold_rd) begin
        // Same destination: oldest first to keep write order; a tie goes to MEM.
        grant_alu = age_alu;
        grant_mem = !age_alu;
      end else if (last_grant == WB_MEM) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else if (alu_full) begin
      grant_alu = 1'b1;
    end else if (mem_full) begin
      grant_mem = 1'b1;
    end
  end

  assign alu_full_nxt = alu_cap || (alu_full && !grant_alu);
  assign mem_full_nxt = mem_cap || (mem_full && !grant_mem);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ru_wr        <= 1'b0;
      rd           <= '0;
      data_wr      <= '0;
      last_grant   <= WB_MEM;
      conflict_cnt <= '0;
      age_alu      <= 1'b0;
      age_mem      <= 1'b0;
    end else begin
      ru_wr <= grant_alu || grant_mem;
      if (grant_alu) begin
        rd         <= alu_hold_rd;
        data_wr    <= alu_hold_data;
        last_grant <= WB_ALU;
      end else if (grant_mem) begin
        rd         <= mem_hold_rd;
        data_wr    <= mem_hold_data;
        last_grant <= WB_MEM;
      end
      if (both_full && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      // A slot is older when it keeps its entry while the other one loads a new one;
      // a fresh capture always makes a slot the younger (or tied) one.
      age_alu <= alu_full_nxt && mem_full_nxt && !alu_cap && (mem_cap || age_alu);
      age_mem <= alu_full_nxt && mem_full_nxt && !mem_cap && (alu_cap || age_mem);
    end
  end

  // Built from registered state only so hazard logic sees no input-to-output path.
  always_comb begin
    busy_mask = '0;
    if (alu_full) busy_mask = busy_mask | (32'd1 << alu_hold_rd);
    if (mem_full) busy_mask = busy_mask | (32'd1 << mem_hold_rd);
    if (ru_wr)    busy_mask = busy_mask | (32'd1 << rd);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset state, single write latency, dead-write drops,
// same-register ordering, round-robin streaming, mid-operation reset, counter saturation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        ru_wr;
  logic [4:0]  rd;
  logic [31:0] data_wr;
  logic [31:0] busy_mask;
  logic [15:0] conflict_cnt;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .PROTECT_X2(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .ru_wr(ru_wr), .rd(rd), .data_wr(data_wr),
    .busy_mask(busy_mask), .conflict_cnt(conflict_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    logic fa, fm;
    int ai, mi;
    logic [31:0] exp_rd, exp_data;

    rstn = 1'b0;
    idle_inputs();
    step();
    step();
    rstn = 1'b1;

    // Reset state
    chk("rst_ru_wr", 32'(ru_wr), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", data_wr, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_alu_rdy", 32'(alu_ready), 32'd1);
    chk("rst_mem_rdy", 32'(mem_ready), 32'd1);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Single ALU write to x5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk("w1_e0_ru_wr", 32'(ru_wr), 32'd0);
    chk("w1_e0_busy", busy_mask, 32'h0000_0020);
    chk("w1_e0_alu_rdy", 32'(alu_ready), 32'd1);
    step();
    chk("w1_e1_ru_wr", 32'(ru_wr), 32'd1);
    chk("w1_e1_rd", 32'(rd), 32'd5);
    chk("w1_e1_data", data_wr, 32'hDEADBEEF);
    chk("w1_e1_busy", busy_mask, 32'h0000_0020);
    step();
    chk("w1_e2_ru_wr", 32'(ru_wr), 32'd0);
    chk("w1_e2_busy", busy_mask, 32'd0);
    chk("w1_e2_rd_hold", 32'(rd), 32'd5);

    // Dead writes: ALU x0, MEM x2
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2;
    chk("drop_alu_rdy", 32'(alu_ready), 32'd1);
    chk("drop_mem_rdy", 32'(mem_ready), 32'd1);
    step();
    idle_inputs();
    chk("drop_e0_busy", busy_mask, 32'd0);
    chk("drop_e0_alu_rdy", 32'(alu_ready), 32'd1);
    chk("drop_e0_mem_rdy", 32'(mem_ready), 32'd1);
    step();
    chk("drop_e1_ru_wr", 32'(ru_wr), 32'd0);
    chk("drop_e1_busy", busy_mask, 32'd0);
    chk("drop_e1_data_hold", data_wr, 32'hDEADBEEF);

    // Same destination captured on one edge: MEM first, then ALU
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hB;
    step();
    idle_inputs();
    chk("x7_e0_busy", busy_mask, 32'h0000_0080);
    chk("x7_e0_alu_rdy", 32'(alu_ready), 32'd0);
    chk("x7_e0_mem_rdy", 32'(mem_ready), 32'd1);
    step();
    chk("x7_e1_ru_wr", 32'(ru_wr), 32'd1);
    chk("x7_e1_rd", 32'(rd), 32'd7);
    chk("x7_e1_data", data_wr, 32'hB);
    chk("x7_e1_cnt", 32'(conflict_cnt), 32'd1);
    step();
    chk("x7_e2_ru_wr", 32'(ru_wr), 32'd1);
    chk("x7_e2_data", data_wr, 32'hA);
    step();
    chk("x7_e3_ru_wr", 32'(ru_wr), 32'd0);
    chk("x7_e3_cnt", 32'(conflict_cnt), 32'd1);

    // Round-robin streaming: ALU x10.., MEM x20..
    do_reset();
    ai = 0; mi = 0;
    for (int k = 0; k < 10; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + ai); alu_data = 32'hA000_0000 | 32'(10 + ai);
      mem_valid = 1'b1; mem_rd = 5'(20 + mi); mem_data = 32'hB000_0000 | 32'(20 + mi);
      if (k == 0) begin
        chk("rr_alu_rdy", 32'(alu_ready), 32'd1);
        chk("rr_mem_rdy", 32'(mem_ready), 32'd1);
      end else begin
        chk("rr_alu_rdy", 32'(alu_ready), 32'(k % 2 == 1));
        chk("rr_mem_rdy", 32'(mem_ready), 32'(k % 2 == 0));
      end
      fa = alu_ready;
      fm = mem_ready;
      step();
      if (fa) ai++;
      if (fm) mi++;
      if (k == 0) begin
        chk("rr_ru_wr", 32'(ru_wr), 32'd0);
      end else begin
        if (k % 2 == 1) begin
          exp_rd   = 32'(10 + (k - 1) / 2);
          exp_data = 32'hA000_0000 | exp_rd;
        end else begin
          exp_rd   = 32'(20 + (k - 2) / 2);
          exp_data = 32'hB000_0000 | exp_rd;
        end
        chk("rr_ru_wr", 32'(ru_wr), 32'd1);
        chk("rr_rd", 32'(rd), exp_rd);
        chk("rr_data", data_wr, exp_data);
      end
      chk("rr_cnt", 32'(conflict_cnt), 32'(k));
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Reset asserted while both slots hold writes and the output is active
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    step();
    idle_inputs();
    chk("mr_e0_busy", busy_mask, 32'h0000_0018);
    step();
    chk("mr_e1_ru_wr", 32'(ru_wr), 32'd1);
    chk("mr_e1_rd", 32'(rd), 32'd3);
    chk("mr_e1_cnt", 32'(conflict_cnt), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_async_ru_wr", 32'(ru_wr), 32'd0);
    chk("mr_async_busy", busy_mask, 32'd0);
    chk("mr_async_cnt", 32'(conflict_cnt), 32'd0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_post_ru_wr", 32'(ru_wr), 32'd0);
      chk("mr_post_busy", busy_mask, 32'd0);
    end

    // Sustained conflict until the counter saturates
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h8;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9;
    step();
    for (int i = 1; i <= 65534; i++) step();
    chk("sat_fffe", 32'(conflict_cnt), 32'h0000_FFFE);
    step();
    chk("sat_ffff", 32'(conflict_cnt), 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", 32'(conflict_cnt), 32'h0000_FFFF);
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
